// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types for the round-robin arbiter around the mux select tree.
package rr_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_OUT     = 2'd2
    } arb_state_e;

    // Number of bits needed to index n entries (minimum 1).
    function automatic int clog2_f(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin winner pick: the source just after 'last' has top priority.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int NUM_IN = 4,
    localparam int IDX_W = clog2_f(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic              any,
    output logic [IDX_W-1:0]  win
);

    logic [2*NUM_IN-1:0] dbl;
    logic [NUM_IN-1:0]   rot;
    logic [IDX_W:0]      shamt;
    logic [IDX_W-1:0]    off;

    always_comb begin
        shamt = {1'b0, last} + {{IDX_W{1'b0}}, 1'b1};
        dbl   = {req, req} >> shamt;
        rot   = dbl[NUM_IN-1:0];
        off   = '0;
        // Scan downward so the lowest set bit of the rotated vector wins.
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        win = last + off + IDX_W'(1);
        any = |req;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the mux select and capturing its result into a valid/ready register.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int SEL_BITS   = 2,
    parameter int DATA_WIDTH = 8,
    localparam int NUM_IN    = 1 << SEL_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     req,
    output logic [NUM_IN-1:0]     gnt,
    output logic [SEL_BITS-1:0]   sel,
    input  logic [DATA_WIDTH-1:0] mux_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SEL_BITS-1:0]   out_src
);

    arb_state_e            state_q, state_d;
    logic [SEL_BITS-1:0]   sel_q, sel_d;
    logic [SEL_BITS-1:0]   last_q, last_d;
    logic [NUM_IN-1:0]     gnt_q, gnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_BITS-1:0]   out_src_q, out_src_d;

    logic                  pick_any;
    logic [SEL_BITS-1:0]   pick_win;

    rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .win  (pick_win)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        gnt_d       = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d           = pick_win;
                    last_d          = pick_win;
                    gnt_d[pick_win] = 1'b1;
                    state_d         = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                out_data_d  = mux_data;
                out_src_d   = sel_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                // gnt is registered, so it is raised on entry to CAPTURE, not in it.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (pick_any) begin
                        sel_d           = pick_win;
                        last_d          = pick_win;
                        gnt_d[pick_win] = 1'b1;
                        state_d         = ST_CAPTURE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            last_q      <= SEL_BITS'(NUM_IN - 1);
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with a behavioural 4-way mux tree.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] mux_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_src;

    logic [7:0] words [4];

    int n_chk;
    int n_pass;

    rr_mux_arbiter #(
        .SEL_BITS   (2),
        .DATA_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .mux_data  (mux_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    assign mux_data = words[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        words[0]  = 8'h3C;
        words[1]  = 8'hA5;
        words[2]  = 8'h5A;
        words[3]  = 8'hC3;
        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_src", 32'(out_src), 32'h0);
        rst = 1'b0;

        // Single request from source 2, then drain to idle.
        req       = 4'b0100;
        out_ready = 1'b1;
        step();
        chk("t1_sel", 32'(sel), 32'd2);
        chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_valid_cap", 32'(out_valid), 32'h0);
        req = 4'b0000;
        step();
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_src", 32'(out_src), 32'd2);
        chk("t1_data", 32'(out_data), 32'h5A);
        chk("t1_gnt_out", 32'(gnt), 32'h0);
        step();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_gnt", 32'(gnt), 32'h0);
        step();
        chk("idle_gnt", 32'(gnt), 32'h0);
        chk("idle_valid", 32'(out_valid), 32'h0);

        // Rotation with all requesters active.
        pulse_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rot_gnt", 32'(gnt), 32'(1 << (k % 4)));
            chk("rot_valid_cap", 32'(out_valid), 32'h0);
            step();
            chk("rot_valid", 32'(out_valid), 32'h1);
            chk("rot_src", 32'(out_src), 32'(k % 4));
            chk("rot_data", 32'(out_data), 32'(words[k % 4]));
            chk("rot_gnt_out", 32'(gnt), 32'h0);
        end
        req = 4'b0000;
        step();
        chk("rot_drain", 32'(out_valid), 32'h0);

        // Backpressure: last is 0, so source 1 wins first.
        req       = 4'b0011;
        out_ready = 1'b0;
        step();
        chk("bp_gnt", 32'(gnt), 32'h2);
        step();
        chk("bp_src0", 32'(out_src), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            chk("bp_hold_src", 32'(out_src), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'hA5);
            chk("bp_hold_gnt", 32'(gnt), 32'h0);
            chk("bp_hold_sel", 32'(sel), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_gnt", 32'(gnt), 32'h1);
        chk("bp_next_sel", 32'(sel), 32'd0);
        chk("bp_handoff_valid", 32'(out_valid), 32'h0);
        req = 4'b0000;
        step();
        chk("bp_next_src", 32'(out_src), 32'd0);
        chk("bp_next_data", 32'(out_data), 32'h3C);
        step();

        // Wrap-around between sources 3 and 0.
        pulse_reset();
        req       = 4'b1001;
        out_ready = 1'b1;
        step();
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        step();
        chk("wrap_src0", 32'(out_src), 32'd0);
        step();
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        chk("wrap_sel3", 32'(sel), 32'd3);
        step();
        chk("wrap_src3", 32'(out_src), 32'd3);
        chk("wrap_data3", 32'(out_data), 32'hC3);
        req = 4'b0000;
        step();

        // Asynchronous reset in the middle of CAPTURE.
        req = 4'b0100;
        step();
        chk("ar_pre_gnt", 32'(gnt), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_sel", 32'(sel), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        step();
        chk("ar_first_gnt", 32'(gnt), 32'h1);
        step();
        chk("ar_first_src", 32'(out_src), 32'd0);
        chk("ar_first_data", 32'(out_data), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
